// File: rtl/safe_code_entry.sv
// Keypad-to-lock controller: buffers BCD key digits, checks them
// against a stored code and drives the unlock/lockout indicators.
module safe_code_entry #(
  parameter int DIGITS = 4,
  parameter logic [4*DIGITS-1:0] CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int OPEN_CYCLES = 500,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyValid,
  input  logic [3:0] KeyCode,
  output logic [3:0] DigitBCD,
  output logic [3:0] DigitCount,
  output logic       Unlocked,
  output logic       Error,
  output logic       Locked,
  output logic [2:0] Tries
);

  localparam int BW = 4 * DIGITS;
  localparam int MAXC = (OPEN_CYCLES > LOCKOUT_CYCLES) ?
                        OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [3:0] FULL = 4'(DIGITS);
  localparam logic [2:0] LIMIT = 3'(MAX_TRIES);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
  } state_t;

  state_t state, state_n;
  logic [BW-1:0] code_buf, code_buf_n;
  logic [3:0] digit, digit_n;
  logic [3:0] count, count_n;
  logic [2:0] tries, tries_n;
  logic [TW-1:0] timer, timer_n;
  logic unlocked, unlocked_n;
  logic error, error_n;
  logic locked, locked_n;

  logic is_digit, is_clear, is_enter;

  assign is_digit = KeyValid && (KeyCode <= 4'd9);
  assign is_clear = KeyValid && (KeyCode == 4'hA);
  assign is_enter = KeyValid && (KeyCode == 4'hB);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      code_buf <= '0;
      digit    <= '0;
      count    <= '0;
      tries    <= '0;
      timer    <= '0;
      unlocked <= 1'b0;
      error    <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      code_buf <= code_buf_n;
      digit    <= digit_n;
      count    <= count_n;
      tries    <= tries_n;
      timer    <= timer_n;
      unlocked <= unlocked_n;
      error    <= error_n;
      locked   <= locked_n;
    end
  end

  always_comb begin
    state_n    = state;
    code_buf_n = code_buf;
    digit_n    = digit;
    count_n    = count;
    tries_n    = tries;
    timer_n    = timer;
    unlocked_n = unlocked;
    error_n    = 1'b0;
    locked_n   = locked;
    unique case (state)
      IDLE, ENTRY: begin
        unique case (1'b1)
          is_digit: begin
            if (count < FULL) begin
              code_buf_n = {code_buf[BW-5:0], KeyCode};
              count_n    = count + 4'd1;
              digit_n    = KeyCode;
              state_n    = ENTRY;
            end
          end
          is_clear: begin
            code_buf_n = '0;
            count_n    = '0;
            digit_n    = '0;
            state_n    = IDLE;
          end
          is_enter: begin
            if (count == FULL) state_n = CHECK;
          end
          default: ;
        endcase
      end
      CHECK: begin
        code_buf_n = '0;
        count_n    = '0;
        digit_n    = '0;
        if (code_buf == CODE) begin
          tries_n    = '0;
          unlocked_n = 1'b1;
          timer_n    = OPEN_LOAD;
          state_n    = OPEN;
        end else begin
          error_n = 1'b1;
          if (tries + 3'd1 == LIMIT) begin
            tries_n  = '0;
            locked_n = 1'b1;
            timer_n  = LOCK_LOAD;
            state_n  = LOCKOUT;
          end else begin
            tries_n = tries + 3'd1;
            state_n = IDLE;
          end
        end
      end
      OPEN: begin
        if (timer == '0) begin
          unlocked_n = 1'b0;
          state_n    = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          locked_n = 1'b0;
          state_n  = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign DigitBCD   = digit;
  assign DigitCount = count;
  assign Unlocked   = unlocked;
  assign Error      = error;
  assign Locked     = locked;
  assign Tries      = tries;

endmodule

// File: tb/tb_safe_code_entry.sv
// Directed bench for safe_code_entry with short open/lockout timers.
module tb_safe_code_entry;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       KeyValid;
  logic [3:0] KeyCode;
  logic [3:0] DigitBCD;
  logic [3:0] DigitCount;
  logic       Unlocked;
  logic       Error;
  logic       Locked;
  logic [2:0] Tries;

  int checks = 0;
  int failures = 0;

  safe_code_entry #(
    .DIGITS(4),
    .CODE(16'h1234),
    .MAX_TRIES(3),
    .OPEN_CYCLES(8),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .KeyValid(KeyValid),
    .KeyCode(KeyCode),
    .DigitBCD(DigitBCD),
    .DigitCount(DigitCount),
    .Unlocked(Unlocked),
    .Error(Error),
    .Locked(Locked),
    .Tries(Tries)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one key for one cycle; returns at the negedge after the
  // sampling edge.
  task automatic press(input logic [3:0] k);
    @(negedge Clock);
    KeyValid = 1'b1;
    KeyCode  = k;
    @(negedge Clock);
    KeyValid = 1'b0;
    KeyCode  = 4'h0;
  endtask

  task automatic code4(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
    press(4'hB);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_unl"}, 8'(Unlocked), 8'h0);
    check({tag, "_err"}, 8'(Error), 8'h0);
    check({tag, "_lck"}, 8'(Locked), 8'h0);
    check({tag, "_cnt"}, 8'(DigitCount), 8'h0);
    check({tag, "_bcd"}, 8'(DigitBCD), 8'h0);
  endtask

  // Called right after Enter returns (block is in CHECK).
  task automatic expect_open(input string tag);
    check({tag, "_chk_unl"}, 8'(Unlocked), 8'h0);
    @(negedge Clock);
    check({tag, "_tries"}, 8'(Tries), 8'h0);
    check({tag, "_bcd"}, 8'(DigitBCD), 8'h0);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_unl_hi"}, 8'(Unlocked), 8'h1);
      @(negedge Clock);
    end
    check({tag, "_unl_lo"}, 8'(Unlocked), 8'h0);
  endtask

  task automatic expect_wrong(input string tag,
                              input logic [2:0] t);
    check({tag, "_chk_err"}, 8'(Error), 8'h0);
    @(negedge Clock);
    check({tag, "_err"}, 8'(Error), 8'h1);
    check({tag, "_tries"}, 8'(Tries), 8'(t));
    check({tag, "_unl"}, 8'(Unlocked), 8'h0);
    check({tag, "_lck"}, 8'(Locked), 8'h0);
    @(negedge Clock);
    check({tag, "_err_lo"}, 8'(Error), 8'h0);
  endtask

  initial begin
    Reset    = 1'b1;
    KeyValid = 1'b0;
    KeyCode  = 4'h0;
    @(negedge Clock);
    @(negedge Clock);
    check_idle_outs("rst");
    check("rst_tries", 8'(Tries), 8'h0);
    Reset = 1'b0;

    press(4'h1);
    check("d1_bcd", 8'(DigitBCD), 8'h1);
    press(4'h2);
    check("d2_bcd", 8'(DigitBCD), 8'h2);
    press(4'h3);
    check("d3_bcd", 8'(DigitBCD), 8'h3);
    press(4'h4);
    check("d4_bcd", 8'(DigitBCD), 8'h4);
    check("d4_cnt", 8'(DigitCount), 8'h4);
    press(4'hB);
    expect_open("ok1");

    code4(16'h1235);
    expect_wrong("w1", 3'd1);
    code4(16'h0000);
    expect_wrong("w2", 3'd2);
    code4(16'h4321);
    check("w3_chk_lck", 8'(Locked), 8'h0);
    @(negedge Clock);
    check("w3_err", 8'(Error), 8'h1);
    check("w3_lck", 8'(Locked), 8'h1);
    check("w3_tries", 8'(Tries), 8'h0);
    for (int i = 0; i < 16; i++) begin
      check("lock_hi", 8'(Locked), 8'h1);
      check("lock_cnt", 8'(DigitCount), 8'h0);
      KeyValid = 1'b1;
      KeyCode  = 4'(i % 10);
      @(negedge Clock);
    end
    KeyValid = 1'b0;
    check("lock_lo", 8'(Locked), 8'h0);
    check("lock_end_cnt", 8'(DigitCount), 8'h0);

    press(4'h9);
    press(4'h8);
    check("c98_cnt", 8'(DigitCount), 8'h2);
    check("c98_bcd", 8'(DigitBCD), 8'h8);
    press(4'hA);
    check("clr_cnt", 8'(DigitCount), 8'h0);
    check("clr_bcd", 8'(DigitBCD), 8'h0);

    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'hB);
    @(negedge Clock);
    check("short_err", 8'(Error), 8'h0);
    check("short_tries", 8'(Tries), 8'h0);
    check("short_cnt", 8'(DigitCount), 8'h3);
    press(4'h4);
    press(4'h5);
    check("fifth_cnt", 8'(DigitCount), 8'h4);
    check("fifth_bcd", 8'(DigitBCD), 8'h4);
    press(4'hB);
    expect_open("ok2");

    code4(16'h9999);
    expect_wrong("ww1", 3'd1);
    code4(16'h1243);
    expect_wrong("ww2", 3'd2);
    code4(16'h1234);
    expect_open("ok3");
    code4(16'h5678);
    expect_wrong("ww3", 3'd1);

    press(4'h7);
    press(4'hC);
    press(4'hD);
    press(4'hE);
    press(4'hF);
    check("ign_cnt", 8'(DigitCount), 8'h1);
    check("ign_bcd", 8'(DigitBCD), 8'h7);
    check("ign_err", 8'(Error), 8'h0);
    check("ign_tries", 8'(Tries), 8'h1);
    press(4'hA);

    code4(16'h1234);
    @(negedge Clock);
    check("ro_unl", 8'(Unlocked), 8'h1);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("ro_async_unl", 8'(Unlocked), 8'h0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check_idle_outs("ro_post");
    check("ro_tries", 8'(Tries), 8'h0);

    code4(16'h1111);
    expect_wrong("rl1", 3'd1);
    code4(16'h2222);
    expect_wrong("rl2", 3'd2);
    code4(16'h3333);
    @(negedge Clock);
    check("rl_lck", 8'(Locked), 8'h1);
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("rl_async_lck", 8'(Locked), 8'h0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check_idle_outs("rl_post");
    check("rl_tries", 8'(Tries), 8'h0);

    code4(16'h1234);
    expect_open("ok4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/safe_code_entry.md
Name: safe_code_entry

Overview:
- Keypad-to-lock controller for the digital safe.
- Accepts debounced key strobes and accumulates BCD digits into an entry buffer.
- Checks the entered code against a stored code and drives the unlock and lockout indicators.
- Its DigitBCD output feeds the BCD-to-7-segment display stage directly downstream; that stage is combinational and is not part of this block.

Parameters:
DIGITS, 4, number of BCD digits in a code (2..8)
CODE, 16'h1234, stored code as packed BCD, most significant digit first; width 4*DIGITS
MAX_TRIES, 3, consecutive wrong codes that trigger lockout (1..7)
OPEN_CYCLES, 500, clock cycles Unlocked stays high
LOCKOUT_CYCLES, 1000, clock cycles Locked stays high

Ports:
Clock  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-high reset
KeyValid  input  1  single-cycle strobe; KeyCode is valid while it is high
KeyCode  input  4  key value: 0-9 digit, 4'hA Clear, 4'hB Enter, 4'hC-4'hF ignored
DigitBCD  output  4  last digit entered, or 0 when the buffer is empty; goes to the display stage
DigitCount  output  4  number of digits currently held in the buffer (0..DIGITS)
Unlocked  output  1  high while the safe is open
Error  output  1  one-cycle pulse on each wrong code
Locked  output  1  high during lockout
Tries  output  3  consecutive wrong attempts so far

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, even mid-operation):
  - state is IDLE;
  - buffer, DigitCount, DigitBCD, Tries and the timer are 0;
  - Unlocked, Error and Locked are 0.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT.
- IDLE/ENTRY, when KeyValid=1:
  - Digit key with DigitCount<DIGITS:
    - buffer <= {buffer[4*DIGITS-5:0], KeyCode};
    - DigitCount+1;
    - DigitBCD <= KeyCode;
    - next state ENTRY.
  - Digit key with DigitCount==DIGITS: ignored (no change).
  - Clear: buffer, DigitCount and DigitBCD go to 0; next state IDLE.
  - Enter with DigitCount==DIGITS: next state CHECK.
  - Enter with DigitCount<DIGITS: ignored; this is not an attempt.
  - KeyCode 4'hC-4'hF: ignored.
- CHECK lasts exactly one cycle. KeyValid is ignored during it. Outputs update on the edge that leaves CHECK.
  - In both cases: buffer, DigitCount and DigitBCD go to 0.
  - Match (buffer==CODE):
    - Tries <= 0;
    - Unlocked <= 1;
    - timer <= OPEN_CYCLES-1;
    - next state OPEN.
  - Mismatch:
    - Error <= 1 for one cycle.
    - If Tries+1==MAX_TRIES: Tries <= 0; Locked <= 1; timer <= LOCKOUT_CYCLES-1; next state LOCKOUT.
    - Otherwise: Tries <= Tries+1; next state IDLE.
- Latency: Enter sampled on edge N puts the block in CHECK. Unlocked, Error or Locked is visible after edge N+1.
- OPEN:
  - All keys are ignored.
  - The timer decrements each cycle.
  - On the edge where the timer is 0: Unlocked <= 0; next state IDLE.
  - Unlocked is high for exactly OPEN_CYCLES cycles.
- LOCKOUT:
  - Same as OPEN, using Locked.
  - Locked is high for exactly LOCKOUT_CYCLES cycles.
  - Keys pressed during lockout are not buffered.
- Timer width is clog2 of the larger of OPEN_CYCLES and LOCKOUT_CYCLES. The timer never wraps.
- Tries persists across IDLE/ENTRY. Only a correct code, a lockout or Reset clears it.
- KeyValid held high for several cycles counts as one key per cycle. Upstream guarantees single-cycle strobes.

Test Plan:
- Bench override: OPEN_CYCLES=8, LOCKOUT_CYCLES=16.
- Reset, then keys 1,2,3,4,B -> DigitBCD goes 1,2,3,4; DigitCount 4. After Enter: CHECK 1 cycle, then Unlocked=1 for exactly 8 cycles, DigitBCD=0, Tries=0, then IDLE.
- Keys 1,2,3,5,B -> one-cycle Error pulse, Tries=1, Unlocked=0. Three wrong codes in a row -> third Error coincides with Locked=1 for 16 cycles, Tries=0. Keys during lockout are ignored; DigitCount stays 0.
- Keys 9,8,A -> DigitCount 0, DigitBCD 0, IDLE. Enter with 3 digits -> no Error, Tries unchanged. Fifth digit after 4 entered -> DigitCount stays 4, buffer unchanged.
- Wrong, wrong, correct -> Unlocked=1 and Tries cleared to 0. A following single wrong code -> Tries=1, no lockout.
- Reset asserted mid-OPEN (cycle 3) and mid-LOCKOUT -> Unlocked/Locked drop immediately (asynchronous). After release: IDLE, all outputs 0.
- KeyCode 4'hC-4'hF with KeyValid -> no state or output change.
